// File: rtl/seq_sort_proc.sv
// Packet processor: captures NUM signed samples, optionally negates, prefix-sums and
// odd-even sorts them, then streams NUM results with a fixed latency for every mode.
module seq_sort_proc #(
  parameter int DATA_W = 9,
  parameter int NUM    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cg_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = $clog2(NUM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);
  localparam logic [CNT_W-1:0] CNT_NUM  = CNT_W'(NUM);
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_IN, S_PRE, S_SORT, S_OUT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         mode_q;
  logic [DATA_W-1:0]  arr_q [NUM];
  logic [DATA_W-1:0]  arr_d [NUM];
  logic               arr_en;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
    return (x == S_MIN) ? S_MAX : -x;
  endfunction

  // One extra bit holds the exact sum; disagreeing top bits mean overflow.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? S_MIN : S_MAX;
    return s[DATA_W-1:0];
  endfunction

  // Next contents of the sample array for the current state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    arr_d = arr_q;
    unique case (state_q)
      S_IDLE: if (in_valid) arr_d[0] = in_mode[0] ? sat_neg(in_data) : in_data;
      S_IN:   if (in_valid) arr_d[cnt_q] = mode_q[0] ? sat_neg(in_data) : in_data;
      S_PRE: begin
        if (mode_q[1]) begin
          for (int k = 1; k < NUM; k++) arr_d[k] = sat_add(arr_d[k-1], arr_q[k]);
        end
      end
      S_SORT: begin
        if (mode_q[2]) begin
          for (int i = 0; i < NUM - 1; i++) begin
            if (i[0] == cnt_q[0] && $signed(arr_q[i]) > $signed(arr_q[i+1])) begin
              arr_d[i]   = arr_q[i+1];
              arr_d[i+1] = arr_q[i];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Enable feeding the array clock gate; a free-running array when cg_en is low.
  assign arr_en = !cg_en
                || (state_q == S_IN) || (state_q == S_PRE) || (state_q == S_SORT)
                || (state_q == S_IDLE && in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is a handful of flops, not a RAM, so clearing it on reset is cheap.
      for (int k = 0; k < NUM; k++) arr_q[k] <= '0;
    end else if (arr_en) begin
      arr_q <= arr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples
      // values from before the edge, independent of statement order.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          if (in_valid) begin
            mode_q  <= in_mode;
            cnt_q   <= CNT_W'(1);
            state_q <= S_IN;
          end
        end
        S_IN: begin
          if (!in_valid) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_PRE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRE: begin
          cnt_q   <= '0;
          state_q <= S_SORT;
        end
        S_SORT: begin
          if (cnt_q == CNT_LAST) begin
            out_valid_q <= 1'b1;
            out_data_q  <= arr_d[0];
            cnt_q       <= CNT_W'(1);
            state_q     <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (cnt_q == CNT_NUM) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            out_data_q <= arr_q[cnt_q];
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sort_proc.sv
// Bench for seq_sort_proc: directed packets, resets, an abort and random packets,
// each compared cycle by cycle against a saturating arithmetic reference model.
module tb_seq_sort_proc;

  typedef int pkt_t [6];

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cg_en = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;
  logic [2:0] in_mode = '0;
  logic       out_valid;
  logic [8:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_sort_proc #(.DATA_W(9), .NUM(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cg_en    (cg_en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic void ref_model(input logic [2:0] m, input pkt_t x, output pkt_t y);
    int acc;
    int t;
    for (int k = 0; k < 6; k++) y[k] = m[0] ? clamp(-x[k]) : x[k];
    if (m[1]) begin
      acc = y[0];
      for (int k = 1; k < 6; k++) begin
        acc  = clamp(acc + y[k]);
        y[k] = acc;
      end
    end
    if (m[2]) begin
      for (int a = 0; a < 5; a++)
        for (int b = a + 1; b < 6; b++)
          if (y[b] < y[a]) begin
            t = y[a]; y[a] = y[b]; y[b] = t;
          end
    end
  endfunction

  task automatic expect_quiet(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check({tag, " quiet valid"}, 9'(out_valid), 9'd0);
      check({tag, " quiet data"}, out_data, 9'd0);
    end
  endtask

  // Drives one packet and checks every cycle up to t18; rst_at >= 5 pulls reset
  // low right after that edge and then expects silence.
  task automatic run_packet(input string tag, input logic [2:0] m, input pkt_t x,
                            input int rst_at);
    pkt_t y;
    logic exp_v;
    ref_model(m, x, y);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check({tag, " in valid"}, 9'(out_valid), 9'd0);
      check({tag, " in data"}, out_data, 9'd0);
      in_valid = 1'b1;
      in_data  = 9'(x[k]);
      in_mode  = (k == 0) ? m : 3'($urandom);
    end
    for (int j = 5; j <= 18; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 9'($urandom);
      in_mode  = 3'($urandom);
      if (j == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst valid"}, 9'(out_valid), 9'd0);
        check({tag, " rst data"}, out_data, 9'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet({tag, " post-rst"}, 20);
        return;
      end
      exp_v = (j >= 12 && j <= 17);
      check($sformatf("%s t%0d valid", tag, j + 1), 9'(out_valid), 9'(exp_v));
      check($sformatf("%s t%0d data", tag, j + 1), out_data,
            exp_v ? 9'(y[j-12]) : 9'd0);
    end
  endtask

  task automatic abort_packet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9'($urandom);
      in_mode  = 3'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    expect_quiet(tag, 20);
  endtask

  initial begin
    pkt_t t1, t2, t3, t4, t5, xr;
    logic [2:0] mr;
    t1 = '{1, 2, 3, 4, 5, 6};
    t2 = '{5, -3, 0, -256, 255, 1};
    t3 = '{100, 100, 100, -50, -200, -200};
    t4 = '{7, -1, 3, -8, 0, 3};
    t5 = '{1, 2, 3, 4, 5, 6};

    rst_n = 1'b0;
    #1;
    check("reset valid", 9'(out_valid), 9'd0);
    check("reset data", out_data, 9'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int cg = 0; cg < 2; cg++) begin
      cg_en = cg[0];
      run_packet($sformatf("T1 cg%0d", cg), 3'b000, t1, -1);
      run_packet($sformatf("T2 cg%0d", cg), 3'b001, t2, -1);
      run_packet($sformatf("T3 cg%0d", cg), 3'b010, t3, -1);
      run_packet($sformatf("T4 cg%0d", cg), 3'b100, t4, -1);
      run_packet($sformatf("T5 cg%0d", cg), 3'b111, t5, -1);
    end

    cg_en = 1'b1;
    run_packet("T6 sort-rst", 3'b111, t5, 8);
    repeat (2) @(negedge clk);
    run_packet("T6 after", 3'b100, t4, -1);
    cg_en = 1'b0;
    run_packet("out-rst", 3'b111, t5, 14);
    repeat (3) @(negedge clk);
    run_packet("out-rst after", 3'b100, t4, -1);

    abort_packet("abort", 3);
    run_packet("after abort", 3'b000, t1, -1);

    for (int p = 0; p < 24; p++) begin
      mr = 3'($urandom);
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 7))
          0:       xr[k] = -256;
          1:       xr[k] = 255;
          default: xr[k] = int'($signed(9'($urandom)));
        endcase
      end
      cg_en = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_packet($sformatf("rand%0d m%0d", p, mr), mr, xr, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
